// File: rtl/riscv_pkg.sv
// Shared RISC-V definitions for the writeback slice: XLEN, opcodes, load func3
// codes and the writeback FIFO entry type.
package riscv_pkg;

    localparam int XLEN = 64;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LD  = 3'b011;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_LWU = 3'b110;

    typedef struct packed {
        logic [4:0]      rd;
        logic [XLEN-1:0] data;
        logic            err;
    } wb_entry_t;

    // Entries that must not reach the register file drain without a write.
    function automatic logic entry_skips_write(input wb_entry_t e);
        return e.err || (e.rd == 5'd0);
    endfunction

endpackage

// File: rtl/load_align.sv
// Load lane selection and sign/zero extension; flags illegal func3 and
// offsets that are not a multiple of the access size.
module load_align
    import riscv_pkg::*;
(
    input  logic [XLEN-1:0] data,
    input  logic [2:0]      func3,
    input  logic [2:0]      addr_lo,
    output logic [XLEN-1:0] result,
    output logic            misaligned
);

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted    = data >> {addr_lo, 3'b000};
        result     = '0;
        misaligned = 1'b0;
        case (func3)
            F3_LB:  result = {{56{shifted[7]}}, shifted[7:0]};
            F3_LBU: result = {56'd0, shifted[7:0]};
            F3_LH: begin
                result     = {{48{shifted[15]}}, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            F3_LHU: begin
                result     = {48'd0, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            F3_LW: begin
                result     = {{32{shifted[31]}}, shifted[31:0]};
                misaligned = (addr_lo[1:0] != 2'b00);
            end
            F3_LWU: begin
                result     = {32'd0, shifted[31:0]};
                misaligned = (addr_lo[1:0] != 2'b00);
            end
            F3_LD: begin
                result     = shifted;
                misaligned = (addr_lo != 3'b000);
            end
            default: misaligned = 1'b1;
        endcase
    end

endmodule

// File: rtl/writeback_unit.sv
// Writeback stage: 2-entry result FIFO feeding the register file plus the
// pending-write scoreboard. Optional decoder bypass ports under WB_FORWARD_EN.
module writeback_unit
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      in_rd,
    input  logic            in_is_load,
    input  logic [2:0]      in_func3,
    input  logic [2:0]      in_addr_lo,
    input  logic [XLEN-1:0] in_alu_result,
    input  logic [XLEN-1:0] in_load_data,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            rf_wr_en,
    input  logic            rf_wr_ready,
    output logic [4:0]      rf_wr_addr,
    output logic [XLEN-1:0] rf_wr_data,
    output logic [31:0]     busy_mask,
    output logic            wb_err
`ifdef WB_FORWARD_EN
    ,
    output logic            fwd_valid,
    output logic [4:0]      fwd_rd,
    output logic [XLEN-1:0] fwd_data
`endif
);

    wb_entry_t       entry_q [2];
    wb_entry_t       entry_d [2];
    logic [1:0]      count_q, count_d;
    logic            head_q, head_d;
    logic [31:0]     busy_q, busy_d;

    logic [XLEN-1:0] load_result;
    logic            load_misaligned;
    wb_entry_t       new_entry;
    wb_entry_t       head_entry;
    logic            wr_ptr;
    logic            push, pop, head_valid;

    load_align u_load_align (
        .data       (in_load_data),
        .func3      (in_func3),
        .addr_lo    (in_addr_lo),
        .result     (load_result),
        .misaligned (load_misaligned)
    );

    assign in_ready   = (count_q != 2'd2);
    assign push       = in_valid && in_ready;
    assign head_valid = (count_q != 2'd0);
    assign head_entry = entry_q[head_q];
    assign wr_ptr     = head_q ^ count_q[0];

    // Skipped heads (err or x0) leave in one cycle regardless of rf_wr_ready.
    assign rf_wr_en   = head_valid && !entry_skips_write(head_entry);
    assign pop        = head_valid && (entry_skips_write(head_entry) || rf_wr_ready);
    assign rf_wr_addr = head_entry.rd;
    assign rf_wr_data = head_entry.data;
    assign wb_err     = pop && head_entry.err;
    assign busy_mask  = busy_q;

`ifdef WB_FORWARD_EN
    assign fwd_valid = rf_wr_en;
    assign fwd_rd    = head_entry.rd;
    assign fwd_data  = head_entry.data;
`endif

    always_comb begin
        new_entry.rd   = in_rd;
        new_entry.data = in_is_load ? load_result : in_alu_result;
        new_entry.err  = in_is_load && load_misaligned;
    end

    always_comb begin
        entry_d = entry_q;
        if (push) begin
            entry_d[wr_ptr] = new_entry;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
        head_d = head_q ^ pop;
    end

    // Clear for the popped head first so a same-cycle issue to that rd wins.
    always_comb begin
        busy_d = busy_q;
        if (pop) begin
            busy_d[head_entry.rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= 2'd0;
            head_q  <= 1'b0;
            busy_q  <= '0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            busy_q  <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        entry_q <= entry_d;
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU/load writes, misaligned loads,
// backpressure, scoreboard set/clear priority, reset mid-operation.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rd;
    logic        in_is_load;
    logic [2:0]  in_func3;
    logic [2:0]  in_addr_lo;
    logic [63:0] in_alu_result;
    logic [63:0] in_load_data;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        rf_wr_en;
    logic        rf_wr_ready;
    logic [4:0]  rf_wr_addr;
    logic [63:0] rf_wr_data;
    logic [31:0] busy_mask;
    logic        wb_err;
`ifdef WB_FORWARD_EN
    logic        fwd_valid;
    logic [4:0]  fwd_rd;
    logic [63:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    writeback_unit dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rd         (in_rd),
        .in_is_load    (in_is_load),
        .in_func3      (in_func3),
        .in_addr_lo    (in_addr_lo),
        .in_alu_result (in_alu_result),
        .in_load_data  (in_load_data),
        .issue_valid   (issue_valid),
        .issue_rd      (issue_rd),
        .rf_wr_en      (rf_wr_en),
        .rf_wr_ready   (rf_wr_ready),
        .rf_wr_addr    (rf_wr_addr),
        .rf_wr_data    (rf_wr_data),
        .busy_mask     (busy_mask),
        .wb_err        (wb_err)
`ifdef WB_FORWARD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_rd        (fwd_rd),
        .fwd_data      (fwd_data)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [4:0] rd, input logic is_load, input logic [2:0] f3,
                        input logic [2:0] addr, input logic [63:0] alu, input logic [63:0] ld);
        in_valid      = 1'b1;
        in_rd         = rd;
        in_is_load    = is_load;
        in_func3      = f3;
        in_addr_lo    = addr;
        in_alu_result = alu;
        in_load_data  = ld;
    endtask

    task automatic issue(input logic [4:0] rd);
        issue_valid = 1'b1;
        issue_rd    = rd;
        tick();
        issue_valid = 1'b0;
    endtask

    task automatic load_case(input string tag, input logic [2:0] f3, input logic [2:0] addr,
                             input logic [63:0] ld, input logic [63:0] exp);
        push(5'd10, 1'b1, f3, addr, 64'd0, ld);
        tick();
        in_valid = 1'b0;
        check_val({tag, "_en"}, rf_wr_en, 1'b1);
        check_val({tag, "_data"}, rf_wr_data, exp);
        tick();
    endtask

    task automatic err_case(input string tag, input logic [2:0] f3, input logic [2:0] addr);
        push(5'd8, 1'b1, f3, addr, 64'd0, 64'hDEAD_BEEF);
        tick();
        in_valid = 1'b0;
        check_val({tag, "_en"}, rf_wr_en, 1'b0);
        check_val({tag, "_err"}, wb_err, 1'b1);
        tick();
        check_val({tag, "_err_gone"}, wb_err, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_rd = '0; in_is_load = 1'b0; in_func3 = '0;
        in_addr_lo = '0; in_alu_result = '0; in_load_data = '0;
        issue_valid = 1'b0; issue_rd = '0; rf_wr_ready = 1'b1;
        tick(); tick();
        check_val("rst_wr_en", rf_wr_en, 1'b0);
        check_val("rst_busy", busy_mask, 32'h0);
        check_val("rst_err", wb_err, 1'b0);
        #2 reset = 1'b0;
        tick();
        check_val("rst_in_ready", in_ready, 1'b1);

        // ALU write to x5
        issue(5'd5);
        check_val("alu_busy_set", busy_mask, 32'h0000_0020);
        push(5'd5, 1'b0, 3'd0, 3'd0, 64'h1234, 64'd0);
        tick();
        in_valid = 1'b0;
        check_val("alu_en", rf_wr_en, 1'b1);
        check_val("alu_addr", rf_wr_addr, 5'd5);
        check_val("alu_data", rf_wr_data, 64'h1234);
        tick();
        check_val("alu_en_done", rf_wr_en, 1'b0);
        check_val("alu_busy_clr", busy_mask, 32'h0);

        // load extension
        load_case("lb",  3'b000, 3'd3, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
        load_case("lbu", 3'b100, 3'd3, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
        load_case("lh",  3'b001, 3'd2, 64'h0000_0000_8001_0000, 64'hFFFF_FFFF_FFFF_8001);
        load_case("lhu", 3'b101, 3'd6, 64'h8001_0000_0000_0000, 64'h0000_0000_0000_8001);
        load_case("lw",  3'b010, 3'd4, 64'h89AB_CDEF_0000_0000, 64'hFFFF_FFFF_89AB_CDEF);
        load_case("lwu", 3'b110, 3'd4, 64'h89AB_CDEF_0000_0000, 64'h0000_0000_89AB_CDEF);
        load_case("ld",  3'b011, 3'd0, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF);

        // misaligned LW to x9
        issue(5'd9);
        push(5'd9, 1'b1, 3'b010, 3'd2, 64'd0, 64'hFFFF);
        tick();
        in_valid = 1'b0;
        check_val("lw_mis_en", rf_wr_en, 1'b0);
        check_val("lw_mis_err", wb_err, 1'b1);
        check_val("lw_mis_busy_held", busy_mask, 32'h0000_0200);
        tick();
        check_val("lw_mis_err_gone", wb_err, 1'b0);
        check_val("lw_mis_busy_clr", busy_mask, 32'h0);
        err_case("f3_111", 3'b111, 3'd0);
        err_case("ld_mis", 3'b011, 3'd1);
        err_case("lh_odd", 3'b001, 3'd3);

        // backpressure: 3 pushes offered while rf_wr_ready=0
        rf_wr_ready = 1'b0;
        push(5'd1, 1'b0, 3'd0, 3'd0, 64'hA1, 64'd0);
        tick();
        check_val("bp_ready_1", in_ready, 1'b1);
        push(5'd2, 1'b0, 3'd0, 3'd0, 64'hB2, 64'd0);
        tick();
        check_val("bp_ready_2", in_ready, 1'b0);
        check_val("bp_head_en", rf_wr_en, 1'b1);
        push(5'd3, 1'b0, 3'd0, 3'd0, 64'hC3, 64'd0);
        tick();
        check_val("bp_ready_3", in_ready, 1'b0);
        check_val("bp_hold_addr", rf_wr_addr, 5'd1);
        tick();
        check_val("bp_hold_addr2", rf_wr_addr, 5'd1);
        check_val("bp_hold_data", rf_wr_data, 64'hA1);
        rf_wr_ready = 1'b1;
        tick();
        check_val("bp_drain_addr2", rf_wr_addr, 5'd2);
        check_val("bp_drain_data2", rf_wr_data, 64'hB2);
        check_val("bp_ready_back", in_ready, 1'b1);
        tick();
        in_valid = 1'b0;
        check_val("bp_drain_addr3", rf_wr_addr, 5'd3);
        check_val("bp_drain_data3", rf_wr_data, 64'hC3);
        check_val("bp_drain_en3", rf_wr_en, 1'b1);
        tick();
        check_val("bp_empty", rf_wr_en, 1'b0);

        // set beats clear on x7
        issue(5'd7);
        check_val("sc_busy7", busy_mask, 32'h0000_0080);
        push(5'd7, 1'b0, 3'd0, 3'd0, 64'h77, 64'd0);
        tick();
        in_valid = 1'b0;
        check_val("sc_en", rf_wr_en, 1'b1);
        issue(5'd7);
        check_val("sc_set_wins", busy_mask, 32'h0000_0080);
        check_val("sc_popped", rf_wr_en, 1'b0);
        issue(5'd0);
        check_val("x0_busy", busy_mask, 32'h0000_0080);

        // rd=0 drains without a write even with rf_wr_ready=0
        rf_wr_ready = 1'b0;
        push(5'd0, 1'b0, 3'd0, 3'd0, 64'h55, 64'd0);
        tick();
        check_val("rd0_en", rf_wr_en, 1'b0);
        push(5'd4, 1'b0, 3'd0, 3'd0, 64'h44, 64'd0);
        tick();
        in_valid = 1'b0;
        check_val("rd0_popped_en", rf_wr_en, 1'b1);
        check_val("rd0_popped_addr", rf_wr_addr, 5'd4);
        check_val("rd0_popped_data", rf_wr_data, 64'h44);
        rf_wr_ready = 1'b1;
        tick();
        check_val("rd0_drained", rf_wr_en, 1'b0);

        // reset with two entries queued
        issue(5'd12);
        issue(5'd13);
        check_val("mid_busy", busy_mask, 32'h0000_3080);
        rf_wr_ready = 1'b0;
        push(5'd12, 1'b0, 3'd0, 3'd0, 64'hCC, 64'd0);
        tick();
        push(5'd13, 1'b0, 3'd0, 3'd0, 64'hDD, 64'd0);
        tick();
        in_valid = 1'b0;
        check_val("mid_full", in_ready, 1'b0);
        check_val("mid_en", rf_wr_en, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_val("mid_rst_en", rf_wr_en, 1'b0);
        check_val("mid_rst_busy", busy_mask, 32'h0);
        tick();
        rf_wr_ready = 1'b1;
        reset = 1'b0;
        tick();
        check_val("post_rst_en", rf_wr_en, 1'b0);
        check_val("post_rst_busy", busy_mask, 32'h0);
        check_val("post_rst_ready", in_ready, 1'b1);
        tick();
        check_val("post_rst_en2", rf_wr_en, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 clk  in  1  rising-edge clock.
REQ-002 reset  in  1  asynchronous, active-high reset.
REQ-003 in_valid  in  1  result presented by execute/memory stage.
REQ-004 in_ready  out  1  unit can accept result; equals (fifo count < 2).
REQ-005 in_rd  in  5  destination register index.
REQ-006 in_is_load  in  1  1 = load result, 0 = ALU result.
REQ-007 in_func3  in  3  load width/sign code; ignored when in_is_load=0.
REQ-008 in_addr_lo  in  3  byte offset of load address within doubleword.
REQ-009 in_alu_result  in  64  ALU result.
REQ-010 in_load_data  in  64  raw little-endian doubleword from data memory.
REQ-011 issue_valid  in  1  decoder issued an instruction writing issue_rd.
REQ-012 issue_rd  in  5  destination of issued instruction.
REQ-013 rf_wr_en  out  1  register-file write request.
REQ-014 rf_wr_ready  in  1  register file accepts write this cycle.
REQ-015 rf_wr_addr  out  5  write index.
REQ-016 rf_wr_data  out  64  write data.
REQ-017 busy_mask  out  32  bit i set = write to xi pending.
REQ-018 wb_err  out  1  one-cycle pulse on illegal/misaligned load.

Function
REQ-019 Transfer in occurs when in_valid and in_ready are both 1; entry (rd, final data, err flag) is pushed into a 2-entry FIFO.
REQ-020 Data formed at push: ALU -> in_alu_result; load -> lane selected by in_addr_lo, extended per func3: 000 LB sign, 001 LH sign, 010 LW sign, 011 LD, 100 LBU zero, 101 LHU zero, 110 LWU zero.
REQ-021 func3=111, or offset not a multiple of access size (LH/LHU odd, LW/LWU not a multiple of 4, LD nonzero), SHALL mark entry err; err entry writes nothing.
REQ-022 rf_wr_en=1 when FIFO non-empty, head not err, head rd != 0; rf_wr_addr/data come from head.
REQ-023 Head pops on rf_wr_en & rf_wr_ready; err or rd=0 heads pop unconditionally in one cycle with rf_wr_en=0.
REQ-024 wb_err pulses the cycle an err head pops.
REQ-025 Latency: result accepted in cycle N is presented on rf_wr_en no earlier than N+1; with rf_wr_ready held 1 it pops in N+1; sustained throughput one result/cycle.
REQ-026 Push and pop in the same cycle keep count unchanged; in_ready depends only on registered count.
REQ-027 issue_valid with issue_rd != 0 sets busy_mask[issue_rd] next cycle.
REQ-028 Any head pop clears busy_mask[head rd], including err pops.
REQ-029 Same-cycle set and clear of the same bit: set wins.
REQ-030 busy_mask[0] always 0.
REQ-031 rf_wr_addr/data hold stable while rf_wr_en=1 and rf_wr_ready=0.

Reset
REQ-032 On reset: FIFO empty, busy_mask=0, rf_wr_en=0, wb_err=0, in_ready=1 after reset deasserts.
REQ-033 Reset mid-operation discards FIFO contents and pending busy bits; no write is issued for discarded entries.

Configuration
REQ-034 Macro WB_FORWARD_EN defined: extra outputs fwd_valid (1), fwd_rd (5), fwd_data (64) mirror the FIFO head whenever it is non-empty, non-err, and rd != 0, for the decoder bypass; combinational from head registers.
REQ-035 Macro undefined: those ports and their logic are absent; all other behaviour identical.

Structure
REQ-036 Shared package riscv_pkg holds func3 load codes, opcode constants, XLEN=64, and the FIFO entry typedef (rd, data, err).
REQ-037 Lane selection and extension live in sub-module load_align (combinational: data, func3, addr_lo -> result, misaligned).

Verification
REQ-038 ALU push rd=5, data 0x1234, rf_wr_ready=1 -> next cycle rf_wr_en=1, addr 5, data 0x1234; busy[5] cleared after pop.
REQ-039 Load LB, func3=000, addr_lo=3, load_data 0x0000_0000_8000_0000 -> rf_wr_data 0xFFFF_FFFF_FFFF_FF80; LBU same -> 0x80.
REQ-040 LW, addr_lo=2 -> no write, wb_err one pulse, busy bit cleared.
REQ-041 rf_wr_ready=0 for 4 cycles with 3 pushes offered -> in_ready drops after 2 entries; writes drain in order once ready=1.
REQ-042 issue_rd=7 and pop of rd=7 same cycle -> busy_mask[7]=1; push rd=0 -> no rf_wr_en, entry pops.
REQ-043 Reset asserted with 2 entries queued -> rf_wr_en=0 and busy_mask=0 immediately; no write after release.
